// File: rtl/serial_alu_ctrl_if.sv
// serial_alu_ctrl_if -- handshake and operand/result bundle for serial_alu_ctrl.
// The master side issues start/op/a/b and observes busy/done/result/err.
// With SERIAL_ALU_OVF_EN defined the bundle also carries the ovf flag.
interface serial_alu_ctrl_if;
   logic        start;
   logic [5:0]  op;
   logic [31:0] a;
   logic [31:0] b;
   logic        busy;
   logic        done;
   logic [31:0] result;
   logic        err;
`ifdef SERIAL_ALU_OVF_EN
   logic        ovf;

   modport master (output start, op, a, b, input busy, done, result, err, ovf);
   modport slave  (input start, op, a, b, output busy, done, result, err, ovf);
`else
   modport master (output start, op, a, b, input busy, done, result, err);
   modport slave  (input start, op, a, b, output busy, done, result, err);
`endif
endinterface

// File: rtl/serial_alu_ctrl.sv
// serial_alu_ctrl -- bit-serial 32-bit ALU (AND, OR, ADD, SUB, SLT).
// One result bit per cycle through a single 1-bit slice, LSB first.
// Sequence: IDLE (accept) -> 32 RUN cycles -> FIN (done pulse) -> IDLE.
// Optional feature macro: SERIAL_ALU_OVF_EN adds the signed-overflow flag ovf.
module serial_alu_ctrl (
   input  logic              clk,
   input  logic              rst_n,
   serial_alu_ctrl_if.slave  bus
);

   localparam logic [5:0] OP_AND = 6'b100100;
   localparam logic [5:0] OP_OR  = 6'b100101;
   localparam logic [5:0] OP_ADD = 6'b100000;
   localparam logic [5:0] OP_SUB = 6'b100010;
   localparam logic [5:0] OP_SLT = 6'b101010;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_FIN  = 2'd2
   } state_t;

   state_t      state_q, state_d;
   logic [4:0]  cnt_q, cnt_d;
   logic        carry_q, carry_d;
   logic [31:0] a_q, a_d;
   logic [31:0] b_q, b_d;
   logic [5:0]  op_q, op_d;
   // Holds the 31 already-computed low bits; bit 31 is merged in on the last RUN cycle.
   logic [30:0] sh_q, sh_d;
   logic [31:0] result_q, result_d;
   logic        busy_q, busy_d;
   logic        done_q, done_d;
   logic        err_q, err_d;
`ifdef SERIAL_ALU_OVF_EN
   logic        ovf_q, ovf_d;
`endif

   logic        a_bit_s;
   logic        b_bit_s;
   logic        sum_s;
   logic        cout_s;
   logic        slice_bit_s;

   // Returns 1 for the five implemented function codes.
   function automatic logic op_supported(input logic [5:0] op);
      logic ok;
      case (op)
         OP_AND, OP_OR, OP_ADD, OP_SUB, OP_SLT: ok = 1'b1;
         default:                               ok = 1'b0;
      endcase
      return ok;
   endfunction

   // Returns 1 for ops whose signed overflow is meaningful (ADD, SUB).
   function automatic logic op_is_addsub(input logic [5:0] op);
      logic hit;
      case (op)
         OP_ADD, OP_SUB: hit = 1'b1;
         default:        hit = 1'b0;
      endcase
      return hit;
   endfunction

   // Single 1-bit slice: operand LSBs, B inverted by op[1] so SUB/SLT form a - b.
   always_comb begin
      a_bit_s = a_q[0];
      b_bit_s = b_q[0] ^ op_q[1];
      sum_s   = a_bit_s ^ b_bit_s ^ carry_q;
      cout_s  = (a_bit_s & b_bit_s) | (a_bit_s & carry_q) | (b_bit_s & carry_q);
      case (op_q)
         OP_AND:                 slice_bit_s = a_bit_s & b_bit_s;
         OP_OR:                  slice_bit_s = a_bit_s | b_bit_s;
         OP_ADD, OP_SUB, OP_SLT: slice_bit_s = sum_s;
         default:                slice_bit_s = 1'b0;
      endcase
   end

   // Next-state and datapath update for the IDLE/RUN/FIN sequencer.
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      carry_d  = carry_q;
      a_d      = a_q;
      b_d      = b_q;
      op_d     = op_q;
      sh_d     = sh_q;
      result_d = result_q;
      done_d   = 1'b0;
      err_d    = 1'b0;
`ifdef SERIAL_ALU_OVF_EN
      ovf_d    = 1'b0;
`endif
      case (state_q)
         S_IDLE: begin
            if (bus.start) begin
               state_d = S_RUN;
               a_d     = bus.a;
               b_d     = bus.b;
               op_d    = bus.op;
               cnt_d   = 5'd0;
               carry_d = bus.op[1];
            end else begin
               state_d = S_IDLE;
            end
         end
         S_RUN: begin
            sh_d    = {slice_bit_s, sh_q[30:1]};
            a_d     = {1'b0, a_q[31:1]};
            b_d     = {1'b0, b_q[31:1]};
            carry_d = cout_s;
            cnt_d   = cnt_q + 5'd1;
            if (cnt_q == 5'd31) begin
               state_d = S_FIN;
               done_d  = 1'b1;
               if (!op_supported(op_q)) begin
                  result_d = 32'd0;
                  err_d    = 1'b1;
               end else if (op_q == OP_SLT) begin
                  result_d = {31'd0, sum_s};
               end else begin
                  result_d = {slice_bit_s, sh_q};
               end
`ifdef SERIAL_ALU_OVF_EN
               ovf_d = op_is_addsub(op_q) & (carry_q ^ cout_s);
`endif
            end else begin
               state_d = S_RUN;
            end
         end
         S_FIN: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
      busy_d = (state_d == S_RUN) || (state_d == S_FIN);
   end

   // State, datapath and registered outputs; reset aborts any operation in progress.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= S_IDLE;
         cnt_q    <= 5'd0;
         carry_q  <= 1'b0;
         a_q      <= 32'd0;
         b_q      <= 32'd0;
         op_q     <= 6'd0;
         sh_q     <= 31'd0;
         result_q <= 32'd0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         err_q    <= 1'b0;
`ifdef SERIAL_ALU_OVF_EN
         ovf_q    <= 1'b0;
`endif
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         carry_q  <= carry_d;
         a_q      <= a_d;
         b_q      <= b_d;
         op_q     <= op_d;
         sh_q     <= sh_d;
         result_q <= result_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
         err_q    <= err_d;
`ifdef SERIAL_ALU_OVF_EN
         ovf_q    <= ovf_d;
`endif
      end
   end

   assign bus.busy   = busy_q;
   assign bus.done   = done_q;
   assign bus.result = result_q;
   assign bus.err    = err_q;
`ifdef SERIAL_ALU_OVF_EN
   assign bus.ovf    = ovf_q;
`endif

endmodule

// File: tb/tb_serial_alu_ctrl.sv
// tb_serial_alu_ctrl -- directed plus random self-checking bench for serial_alu_ctrl.
// Expected results come from a plain-arithmetic model of the ALU ops.
// Define SERIAL_ALU_OVF_EN for both RTL and bench to also check ovf.
module tb_serial_alu_ctrl;

   localparam logic [5:0] OP_AND = 6'b100100;
   localparam logic [5:0] OP_OR  = 6'b100101;
   localparam logic [5:0] OP_ADD = 6'b100000;
   localparam logic [5:0] OP_SUB = 6'b100010;
   localparam logic [5:0] OP_SLT = 6'b101010;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   int   n_cmp  = 0;
   int   n_fail = 0;

   always #5 clk = ~clk;

   serial_alu_ctrl_if bus ();

   serial_alu_ctrl dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Reference behaviour: what the finished operation must report.
   task automatic model(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] r, output logic e, output logic o);
      logic [31:0] d;
      e = 1'b0;
      o = 1'b0;
      case (op)
         OP_AND: r = a & b;
         OP_OR:  r = a | b;
         OP_ADD: begin
            r = a + b;
            o = (a[31] == b[31]) && (r[31] != a[31]);
         end
         OP_SUB: begin
            r = a - b;
            o = (a[31] != b[31]) && (r[31] != a[31]);
         end
         OP_SLT: begin
            d = a - b;
            r = {31'd0, d[31]};
         end
         default: begin
            r = 32'd0;
            e = 1'b1;
         end
      endcase
   endtask

   // One operation: start, optional mid-run disturbance, then check done timing and values.
   task automatic run_op(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b,
                         input bit disturb, input string tag);
      logic [31:0] exp_r, got_r;
      logic        exp_e, exp_o, got_e, got_o, got_busy;
      int          lat, dones;
      model(op, a, b, exp_r, exp_e, exp_o);
      got_r = 32'd0; got_e = 1'b0; got_o = 1'b0; got_busy = 1'b0;
      lat = 0; dones = 0;
      bus.start = 1'b1; bus.op = op; bus.a = a; bus.b = b;
      tick();
      check({tag, "_busy_after_accept"}, {31'd0, bus.busy}, 32'd1);
      bus.start = 1'b0;
      for (int i = 1; i <= 40; i++) begin
         if (disturb && i == 10) begin
            bus.start = 1'b1;
            bus.a  = 32'($urandom);
            bus.b  = 32'($urandom);
            bus.op = 6'($urandom_range(0, 63));
         end
         if (disturb && i == 11) bus.start = 1'b0;
         tick();
         if (bus.done === 1'b1) begin
            dones++;
            if (dones == 1) begin
               lat = i;
               got_r = bus.result;
               got_e = bus.err;
               got_busy = bus.busy;
`ifdef SERIAL_ALU_OVF_EN
               got_o = bus.ovf;
`endif
            end
         end
      end
      // Accept cycle is cycle 0; done belongs to cycle 33, i.e. 32 edges after the accept edge.
      check({tag, "_latency"}, 32'(lat), 32'd32);
      check({tag, "_done_count"}, 32'(dones), 32'd1);
      check({tag, "_result"}, got_r, exp_r);
      check({tag, "_err"}, {31'd0, got_e}, {31'd0, exp_e});
      check({tag, "_busy_at_done"}, {31'd0, got_busy}, 32'd1);
`ifdef SERIAL_ALU_OVF_EN
      check({tag, "_ovf"}, {31'd0, got_o}, {31'd0, exp_o});
`endif
      check({tag, "_idle_busy"}, {31'd0, bus.busy}, 32'd0);
      check({tag, "_result_hold"}, bus.result, exp_r);
   endtask

   initial begin
      logic [5:0]  ops [6];
      logic [31:0] ra, rb, exp_r;
      logic        exp_e, exp_o;
      int          gap, dones;
      bit          seen_low;
      ops[0] = OP_AND; ops[1] = OP_OR; ops[2] = OP_ADD;
      ops[3] = OP_SUB; ops[4] = OP_SLT; ops[5] = 6'b000000;
      bus.start = 1'b0; bus.op = 6'd0; bus.a = 32'd0; bus.b = 32'd0;

      // Reset state
      tick(); tick();
      check("rst_busy",   {31'd0, bus.busy}, 32'd0);
      check("rst_done",   {31'd0, bus.done}, 32'd0);
      check("rst_result", bus.result, 32'd0);
      check("rst_err",    {31'd0, bus.err}, 32'd0);
`ifdef SERIAL_ALU_OVF_EN
      check("rst_ovf",    {31'd0, bus.ovf}, 32'd0);
`endif
      rst_n = 1'b1;
      tick();

      // Directed vectors
      run_op(OP_ADD, 32'h0000_0005, 32'h0000_0003, 1'b0, "add_5_3");
      run_op(OP_SUB, 32'h0000_0000, 32'h0000_0001, 1'b0, "sub_0_1");
      run_op(OP_SLT, 32'h0000_0000, 32'h0000_0001, 1'b0, "slt_0_1");
      run_op(OP_SLT, 32'h0000_0003, 32'h0000_0002, 1'b0, "slt_3_2");
      run_op(OP_AND, 32'hF0F0_F0F0, 32'hFF00_FF00, 1'b0, "and");
      run_op(OP_OR,  32'hF0F0_F0F0, 32'hFF00_FF00, 1'b0, "or");
      run_op(6'b000000, 32'h1234_5678, 32'h9ABC_DEF0, 1'b0, "bad_op");
      run_op(OP_ADD, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, "add_ovf");
      run_op(OP_SUB, 32'h8000_0000, 32'h0000_0001, 1'b0, "sub_ovf");
      run_op(OP_ADD, 32'h0000_0001, 32'h0000_0001, 1'b0, "add_1_1");

      // Start pulse and operand changes mid-RUN must not disturb the operation
      run_op(OP_ADD, 32'hDEAD_BEEF, 32'h0123_4567, 1'b1, "disturb_add");
      run_op(OP_SUB, 32'h0000_1000, 32'h0000_2000, 1'b1, "disturb_sub");

      // Reset in the middle of RUN: aborts with no done, result cleared at once
      bus.start = 1'b1; bus.op = OP_ADD; bus.a = 32'h1111_1111; bus.b = 32'h2222_2222;
      tick();
      bus.start = 1'b0;
      for (int i = 0; i < 16; i++) tick();
      #2 rst_n = 1'b0;
      #1;
      check("midrst_busy",   {31'd0, bus.busy}, 32'd0);
      check("midrst_done",   {31'd0, bus.done}, 32'd0);
      check("midrst_result", bus.result, 32'd0);
      tick();
      rst_n = 1'b1;
      dones = 0;
      for (int i = 0; i < 40; i++) begin
         tick();
         if (bus.done === 1'b1) dones++;
      end
      check("midrst_no_done", 32'(dones), 32'd0);
      run_op(OP_OR, 32'h0F00_0000, 32'h0000_00F0, 1'b0, "after_rst");

      // Random operations against the model
      for (int k = 0; k < 20; k++) begin
         ra = 32'($urandom);
         rb = 32'($urandom);
         run_op(ops[$urandom_range(0, 5)], ra, rb, 1'b0, $sformatf("rand%0d", k));
      end

      // Start held high: back-to-back operations, new accept every 34 cycles
      ra = 32'($urandom);
      rb = 32'($urandom);
      model(OP_ADD, ra, rb, exp_r, exp_e, exp_o);
      bus.start = 1'b1; bus.op = OP_ADD; bus.a = ra; bus.b = rb;
      tick();
      check("hold_busy_accept", {31'd0, bus.busy}, 32'd1);
      gap = 0; seen_low = 1'b0;
      for (int i = 1; i <= 80; i++) begin
         tick();
         if (bus.done === 1'b1) check("hold_result", bus.result, exp_r);
         if (bus.busy === 1'b0) seen_low = 1'b1;
         if (seen_low && bus.busy === 1'b1 && gap == 0) gap = i;
         if (gap != 0) break;
      end
      check("hold_accept_gap", 32'(gap), 32'd34);
      bus.start = 1'b0;
      for (int i = 0; i < 40; i++) tick();
      check("hold_final_result", bus.result, exp_r);
      check("hold_final_idle", {31'd0, bus.busy}, 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
